bench_sweep_ctrl: RTL

BENCH_SWEEP_CTRL -- requirements
Module: bench_sweep_ctrl

---
 rtl/bench_sweep_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/bench_sweep_ctrl.sv
// Sweep controller that drives every input vector to two netlist variants, compares their
// responses, and reports the mismatch count, the first failing vector and a MISR signature.
module bench_sweep_ctrl #(
  parameter int IN_W   = 5,
  parameter int OUT_W  = 17,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [IN_W-1:0]   vec_out,
  input  logic [OUT_W-1:0]  ref_resp,
  input  logic [OUT_W-1:0]  dut_resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IN_W:0]     mism_cnt,
  output logic [IN_W-1:0]   first_bad_vec,
  output logic [OUT_W-1:0]  first_bad_diff,
  output logic [31:0]       sig
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    CAPT = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam logic [3:0]      SETTLE_LD = 4'(SETTLE);
  localparam logic [IN_W-1:0] LAST_VEC  = {IN_W{1'b1}};
  localparam logic [IN_W-1:0] VEC_ONE   = IN_W'(1);
  localparam logic [IN_W:0]   CNT_ONE   = (IN_W+1)'(1);
  localparam logic [31:0]     MISR_POLY = 32'h04C1_1DB7;

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [OUT_W-1:0] d);
    misr_step = {s[30:0], 1'b0} ^ (s[31] ? MISR_POLY : 32'h0000_0000) ^ 32'(d);
  endfunction

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic [IN_W-1:0]    vec_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [IN_W:0]      mism_q;
  logic [IN_W-1:0]    fbv_q;
  logic [OUT_W-1:0]   fbd_q;
  logic [31:0]        sig_q;

  logic [OUT_W-1:0]   diff_d;
  logic               mismatch_d;
  logic [IN_W:0]      mism_d;

  // Compare the two responses and form the candidate mismatch count for this capture
  always_comb begin
    diff_d     = ref_resp ^ dut_resp;
    mismatch_d = |diff_d;
    if (mismatch_d) begin
      mism_d = mism_q + CNT_ONE;
    end else begin
      mism_d = mism_q;
    end
  end

  // Sweep sequencer: state, stimulus vector, result registers and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mism_q  <= '0;
      fbv_q   <= '0;
      fbd_q   <= '0;
      sig_q   <= 32'h0000_0000;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start && !abort) begin
            state_q <= HOLD;
            cnt_q   <= SETTLE_LD;
            vec_q   <= '0;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            mism_q  <= '0;
            fbv_q   <= '0;
            fbd_q   <= '0;
            sig_q   <= 32'h0000_0000;
          end
        end
        HOLD: begin
          if (abort) begin
            state_q <= IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q <= CAPT;
            end
          end
        end
        CAPT: begin
          // An abort here drops the capture so results reflect only completed vectors
          if (abort) begin
            state_q <= IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else begin
            mism_q <= mism_d;
            sig_q  <= misr_step(sig_q, dut_resp);
            if (mismatch_d && (mism_q == '0)) begin
              fbv_q <= vec_q;
              fbd_q <= diff_d;
            end
            if (vec_q != LAST_VEC) begin
              vec_q   <= vec_q + VEC_ONE;
              cnt_q   <= SETTLE_LD;
              state_q <= HOLD;
            end else begin
              state_q <= FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (mism_d == '0);
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          vec_q   <= '0;
        end
        default: begin
          state_q <= IDLE;
          vec_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign vec_out        = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign mism_cnt       = mism_q;
  assign first_bad_vec  = fbv_q;
  assign first_bad_diff = fbd_q;
  assign sig            = sig_q;

endmodule
